// File: rtl/ultra_pkg.sv
// Shared definitions for the HC-SR04 ultrasonic controllers: FSM encoding,
// shot result record and time-to-cycle conversion helpers.
package ultra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_MEASURE,
    ST_REPORT,
    ST_GUARD
  } ultra_state_e;

  // Outcome of one shot, produced on the transition into REPORT.
  typedef struct packed {
    logic        timeout;
    logic [31:0] cycles;
  } ultra_shot_t;

  function automatic logic [31:0] us_to_cycles(input longint unsigned freq,
                                               input longint unsigned us);
    return 32'((freq / 64'd1_000_000) * us);
  endfunction

  function automatic logic [31:0] ms_to_cycles(input longint unsigned freq,
                                               input longint unsigned ms);
    return 32'((freq / 64'd1_000) * ms);
  endfunction

  // Round-trip echo time for an object at cm, in clock cycles (truncated).
  function automatic logic [31:0] detect_cycles(input longint unsigned freq,
                                                input longint unsigned cm,
                                                input longint unsigned sound_mps);
    return 32'((freq * cm * 64'd2) / (sound_mps * 64'd100));
  endfunction

endpackage

// File: rtl/ultra_rr_pick.sv
// Round-robin pick: first enabled sensor strictly after 'last', wrapping.
// If only 'last' itself is enabled it is picked again.
module ultra_rr_pick #(
  parameter  int NUM_SENSORS = 4,
  localparam int IW          = $clog2(NUM_SENSORS)
) (
  input  logic [NUM_SENSORS-1:0] mask,
  input  logic [IW-1:0]          last,
  output logic [IW-1:0]          next_idx,
  output logic                   any
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest enabled one wins.
  always_comb begin
    next_idx = last;
    any      = |mask;
    idx      = '0;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_SENSORS);
      if (mask[idx]) next_idx = idx;
    end
  end

endmodule

// File: rtl/ultra_scheduler.sv
// Time-multiplexed scheduler for several HC-SR04 sensors: fires one trigger
// at a time in round-robin order, times the echo, reports and keeps a
// per-sensor detect/timeout flag.
module ultra_scheduler
  import ultra_pkg::*;
#(
  parameter  int unsigned CLOCK_FREQ       = 50_000_000,
  parameter  int          NUM_SENSORS      = 4,
  parameter  int unsigned TRIG_US          = 10,
  parameter  int unsigned GUARD_MS         = 10,
  parameter  int unsigned WAIT_TIMEOUT_US  = 30_000,
  parameter  int unsigned COUNT_TIMEOUT_US = 30_000,
  parameter  int unsigned DETECT_CM        = 15,
  parameter  int unsigned SOUND_SPEED      = 343,
  localparam int          IW               = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] enable_mask_i,
  input  logic [NUM_SENSORS-1:0] echo_i,
  output logic [NUM_SENSORS-1:0] trigger_o,
  output logic [NUM_SENSORS-1:0] object_detected_o,
  output logic [NUM_SENSORS-1:0] timeout_error_o,
  output logic                   result_valid_o,
  output logic [IW-1:0]          result_idx_o,
  output logic [31:0]            result_cycles_o,
  output logic                   busy_o
);

  localparam logic [31:0] TRIG_CYC   = us_to_cycles(64'(CLOCK_FREQ), 64'(TRIG_US));
  localparam logic [31:0] GUARD_CYC  = ms_to_cycles(64'(CLOCK_FREQ), 64'(GUARD_MS));
  localparam logic [31:0] WAIT_CYC   = us_to_cycles(64'(CLOCK_FREQ), 64'(WAIT_TIMEOUT_US));
  localparam logic [31:0] COUNT_CYC  = us_to_cycles(64'(CLOCK_FREQ), 64'(COUNT_TIMEOUT_US));
  localparam logic [31:0] DETECT_CYC = detect_cycles(64'(CLOCK_FREQ), 64'(DETECT_CM),
                                                     64'(SOUND_SPEED));

  ultra_state_e state, state_n;
  logic [IW-1:0] sel, sel_n;          // sel doubles as the last-served index
  logic [31:0]   cnt, cnt_n, cnt_inc;
  logic [1:0]    start_pipe;          // holds off scheduling until echo sync is primed
  ultra_shot_t   res_n;

  logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_s3;
  logic                   echo_rise, echo_fall;
  logic [IW-1:0]          pick;
  logic                   any_en;

  ultra_rr_pick #(.NUM_SENSORS(NUM_SENSORS)) u_pick (
    .mask     (enable_mask_i),
    .last     (sel),
    .next_idx (pick),
    .any      (any_en)
  );

  // Two-flop synchronizer; echo_s3 is only edge history for the selected bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
    end else begin
      echo_s1 <= echo_i;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_rise = echo_s2[sel] & ~echo_s3[sel];
  assign echo_fall = ~echo_s2[sel] & echo_s3[sel];
  assign cnt_inc   = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign busy_o    = (state != ST_IDLE);

  // State register, shared counter and start-up delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= IW'(NUM_SENSORS - 1);
      cnt        <= '0;
      start_pipe <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      cnt        <= cnt_n;
      start_pipe <= {start_pipe[0], 1'b1};
    end
  end

  // Next-state logic; res_n carries the shot outcome into REPORT.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt_inc;
    res_n   = '0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (start_pipe[1] && any_en) begin
          sel_n   = pick;
          state_n = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt >= TRIG_CYC - 32'd1) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end
      end
      ST_WAIT: begin
        if (echo_rise) begin
          state_n = ST_MEASURE;
          cnt_n   = '0;
        end else if (cnt >= WAIT_CYC - 32'd1) begin
          state_n     = ST_REPORT;
          res_n.timeout = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_n      = ST_REPORT;
          res_n.cycles = cnt;
        end else if (cnt >= COUNT_CYC - 32'd1) begin
          state_n       = ST_REPORT;
          res_n.timeout = 1'b1;
          res_n.cycles  = COUNT_CYC;
        end
      end
      ST_REPORT: begin
        state_n = ST_GUARD;
        cnt_n   = '0;
      end
      ST_GUARD: begin
        if (cnt >= GUARD_CYC - 32'd1) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_o         <= '0;
      result_valid_o    <= 1'b0;
      result_idx_o      <= '0;
      result_cycles_o   <= '0;
      object_detected_o <= '0;
      timeout_error_o   <= '0;
    end else begin
      trigger_o      <= (state_n == ST_PULSE) ? (NUM_SENSORS'(1) << sel_n) : '0;
      result_valid_o <= (state_n == ST_REPORT);
      if (state_n == ST_REPORT) begin
        result_idx_o           <= sel;
        result_cycles_o        <= res_n.cycles;
        object_detected_o[sel] <= ~res_n.timeout && (res_n.cycles <= DETECT_CYC);
        timeout_error_o[sel]   <= res_n.timeout;
      end
      // Disabled sensors lose stale flags once IDLE sees them masked off.
      if (state == ST_IDLE) begin
        object_detected_o <= object_detected_o & enable_mask_i;
        timeout_error_o   <= timeout_error_o & enable_mask_i;
      end
    end
  end

endmodule
